wb_sequencer: RTL and testbench



---
 rtl/wb_sequencer_if.sv | 27 ++
 rtl/wb_sequencer.sv | 163 ++++++++++++++++
 tb/tb_wb_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// Request/status and write-back control bundle between an instruction sequencer client
// and wb_sequencer. The slave modport is the sequencer side.
interface wb_sequencer_if;
    logic       req;
    logic [2:0] op;
    logic [4:0] in_rt;
    logic [4:0] in_rd;
    logic [4:0] in_rs;
    logic       mem_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] reg_dst;
    logic [1:0] wb_src;
    logic       reg_write;
    logic [4:0] dest_idx;

    modport slave (
        input  req, op, in_rt, in_rd, in_rs, mem_ready,
        output busy, done, err, reg_dst, wb_src, reg_write, dest_idx
    );

    modport master (
        output req, op, in_rt, in_rd, in_rs, mem_ready,
        input  busy, done, err, reg_dst, wb_src, reg_write, dest_idx
    );
endinterface

// File: rtl/wb_sequencer.sv
// Register write-back sequencer: IDLE -> (WAIT_MEM) -> WB1 -> (WB2 for POP).
// Optional macro WB_ZERO_GUARD_EN suppresses reg_write for writes to register index 0.
module wb_sequencer (
    input  logic               clk,
    input  logic               reset,
    wb_sequencer_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WB1      = 2'd2,
        S_WB2      = 2'd3
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ITYPE = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_JAL   = 3'b011;
    localparam logic [2:0] OP_PUSH  = 3'b100;
    localparam logic [2:0] OP_POP   = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    localparam logic [2:0] DST_RT = 3'b000;
    localparam logic [2:0] DST_RD = 3'b001;
    localparam logic [2:0] DST_RS = 3'b010;
    localparam logic [2:0] DST_RA = 3'b011;
    localparam logic [2:0] DST_SP = 3'b100;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SRC_SPA = 2'b11;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_op;
    logic [4:0] r_rt;
    logic [4:0] r_rd;
    logic [4:0] r_rs;
    logic [3:0] r_cnt;
    logic       r_nop_done;
    logic       r_err;

    logic       w_accept;
    logic       w_nop_done;
    logic       w_err_set;
    logic       w_wr;
    logic       w_done_wb;
    logic [2:0] w_reg_dst;
    logic [1:0] w_wb_src;
    logic [4:0] w_dest_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op       <= 3'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_rs       <= 5'd0;
            r_cnt      <= 4'd0;
            r_nop_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_nop_done <= w_nop_done;
            r_err      <= w_err_set;
            if (w_accept) begin
                r_op <= bus.op;
                r_rt <= bus.in_rt;
                r_rd <= bus.in_rd;
                r_rs <= bus.in_rs;
            end
            // Held at zero outside WAIT_MEM, so every entry starts counting from 0.
            if (r_state == S_WAIT_MEM) r_cnt <= r_cnt + 4'd1;
            else                       r_cnt <= 4'd0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_nop_done   = 1'b0;
        w_err_set    = 1'b0;
        w_wr         = 1'b0;
        w_done_wb    = 1'b0;
        w_reg_dst    = DST_RT;
        w_wb_src     = SRC_ALU;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept = 1'b1;
                    case (bus.op)
                        OP_RTYPE, OP_ITYPE, OP_JAL:  w_next_state = S_WB1;
                        OP_LOAD, OP_POP, OP_PUSH:    w_next_state = S_WAIT_MEM;
                        OP_NOP:                      w_nop_done   = 1'b1;
                        default:                     w_err_set    = 1'b1;
                    endcase
                end
            end
            S_WAIT_MEM: begin
                // mem_ready wins over the timeout on the final count.
                if (bus.mem_ready) begin
                    w_next_state = S_WB1;
                end else if (r_cnt == 4'd15) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            S_WB1: begin
                w_wr      = 1'b1;
                w_done_wb = (r_op != OP_POP);
                w_next_state = (r_op == OP_POP) ? S_WB2 : S_IDLE;
                case (r_op)
                    OP_RTYPE: begin w_reg_dst = DST_RD; w_wb_src = SRC_ALU; end
                    OP_ITYPE: begin w_reg_dst = DST_RT; w_wb_src = SRC_ALU; end
                    OP_LOAD:  begin w_reg_dst = DST_RT; w_wb_src = SRC_MEM; end
                    OP_JAL:   begin w_reg_dst = DST_RA; w_wb_src = SRC_PC4; end
                    OP_PUSH:  begin w_reg_dst = DST_SP; w_wb_src = SRC_SPA; end
                    OP_POP:   begin w_reg_dst = DST_RT; w_wb_src = SRC_MEM; end
                    default: begin
                        w_wr      = 1'b0;
                        w_done_wb = 1'b0;
                    end
                endcase
            end
            S_WB2: begin
                w_wr         = 1'b1;
                w_done_wb    = 1'b1;
                w_reg_dst    = DST_SP;
                w_wb_src     = SRC_SPA;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_dest_idx = 5'd0;
        if (w_wr) begin
            case (w_reg_dst)
                DST_RT:  w_dest_idx = r_rt;
                DST_RD:  w_dest_idx = r_rd;
                DST_RS:  w_dest_idx = r_rs;
                DST_RA:  w_dest_idx = 5'd31;
                DST_SP:  w_dest_idx = 5'd29;
                default: w_dest_idx = 5'd0;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = w_done_wb | r_nop_done;
    assign bus.err      = r_err;
    assign bus.reg_dst  = w_wr ? w_reg_dst : 3'd0;
    assign bus.wb_src   = w_wr ? w_wb_src  : 2'd0;
    assign bus.dest_idx = w_dest_idx;
`ifdef WB_ZERO_GUARD_EN
    assign bus.reg_write = w_wr && (w_dest_idx != 5'd0);
`else
    assign bus.reg_write = w_wr;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomized transaction bench for wb_sequencer; expected cycle traces come from a
// transaction-level model of the write-back rules.
module tb_wb_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    wb_sequencer_if bus ();

    wb_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {busy, done, err, reg_write, reg_dst, wb_src, dest_idx}
    logic [13:0] exp_q[$];
    int          pol_q[$];   // mem_ready during that cycle: 0 low, 1 high, 2 random

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [13:0] observed();
        return {bus.busy, bus.done, bus.err, bus.reg_write, bus.reg_dst, bus.wb_src, bus.dest_idx};
    endfunction

    function automatic logic [13:0] e_wr(input logic [2:0] dst, input logic [1:0] src,
                                         input logic [4:0] idx, input logic dn);
        logic we;
        we = 1'b1;
`ifdef WB_ZERO_GUARD_EN
        if (idx == 5'd0) we = 1'b0;
`endif
        return {1'b1, dn, 1'b0, we, dst, src, idx};
    endfunction

    function automatic logic [13:0] e_idle(input logic dn, input logic er);
        return {1'b0, dn, er, 11'd0};
    endfunction

    function automatic logic [13:0] e_wait();
        return {1'b1, 13'd0};
    endfunction

    // k = wait-cycle index (0..15) at which mem_ready rises, or -1 for none (timeout)
    task automatic build(input logic [2:0] op, input logic [4:0] rt, input logic [4:0] rd, input int k);
        exp_q.delete();
        pol_q.delete();
        if (op == 3'd2 || op == 3'd4 || op == 3'd5) begin
            for (int j = 0; j < 16; j++) begin
                if (k >= 0 && j > k) break;
                exp_q.push_back(e_wait());
                pol_q.push_back((j == k) ? 1 : 0);
            end
            if (k < 0) begin
                exp_q.push_back(e_idle(1'b0, 1'b1));
                pol_q.push_back(2);
                return;
            end
        end
        case (op)
            3'd0: exp_q.push_back(e_wr(3'd1, 2'd0, rd, 1'b1));
            3'd1: exp_q.push_back(e_wr(3'd0, 2'd0, rt, 1'b1));
            3'd2: exp_q.push_back(e_wr(3'd0, 2'd1, rt, 1'b1));
            3'd3: exp_q.push_back(e_wr(3'd3, 2'd2, 5'd31, 1'b1));
            3'd4: exp_q.push_back(e_wr(3'd4, 2'd3, 5'd29, 1'b1));
            3'd5: begin
                exp_q.push_back(e_wr(3'd0, 2'd1, rt, 1'b0));
                pol_q.push_back(2);
                exp_q.push_back(e_wr(3'd4, 2'd3, 5'd29, 1'b1));
            end
            3'd6: exp_q.push_back(e_idle(1'b1, 1'b0));
            default: exp_q.push_back(e_idle(1'b0, 1'b1));
        endcase
        pol_q.push_back(2);
    endtask

    // Called right after a falling edge; returns right after the falling edge of the trailing idle cycle.
    task automatic run_txn(input string name, input logic [2:0] op, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] rs, input int k);
        build(op, rt, rd, k);
        bus.req       = 1'b1;
        bus.op        = op;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_rs     = rs;
        bus.mem_ready = 1'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_val($sformatf("%s.c%0d", name, i), 32'(observed()), 32'(exp_q[i]));
            // While busy, keep requesting with scrambled fields: it must be ignored.
            bus.req   = (exp_q[i][13] && i != exp_q.size() - 1);
            bus.op    = 3'($urandom);
            bus.in_rt = 5'($urandom);
            bus.in_rd = 5'($urandom);
            bus.in_rs = 5'($urandom);
            if (pol_q[i] == 0)      bus.mem_ready = 1'b0;
            else if (pol_q[i] == 1) bus.mem_ready = 1'b1;
            else                    bus.mem_ready = 1'($urandom);
        end
        @(negedge clk);
        check_val($sformatf("%s.idle", name), 32'(observed()), 32'(e_idle(1'b0, 1'b0)));
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b0;
        bus.req       = 1'b0;
        bus.op        = 3'd0;
        bus.in_rt     = 5'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs     = 5'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_state", 32'(observed()), 32'd0);
        reset = 1'b1;

        // First accept on the first rising edge after release.
        run_txn("rtype_rd5", 3'd0, 5'd3, 5'd5, 5'd7, 0);
        run_txn("pop_rt8",   3'd5, 5'd8, 5'd1, 5'd2, 3);
        run_txn("load_tmo",  3'd2, 5'd9, 5'd1, 5'd2, -1);
        run_txn("load_k15",  3'd2, 5'd9, 5'd1, 5'd2, 15);
        run_txn("jal",       3'd3, 5'd4, 5'd6, 5'd2, 0);
        run_txn("itype_rt0", 3'd1, 5'd0, 5'd6, 5'd2, 0);
        run_txn("illegal",   3'd7, 5'd4, 5'd6, 5'd2, 0);
        run_txn("nop",       3'd6, 5'd4, 5'd6, 5'd2, 0);
        run_txn("push_k0",   3'd4, 5'd4, 5'd6, 5'd2, 0);

        // POP aborted by reset in WB1
        bus.req = 1'b1; bus.op = 3'd5; bus.in_rt = 5'd8; bus.in_rd = 5'd1; bus.in_rs = 5'd2;
        bus.mem_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_val($sformatf("poprst.w%0d", j), 32'(observed()), 32'(e_wait()));
            bus.req = 1'b0;
            bus.mem_ready = (j == 3);
        end
        @(negedge clk);
        check_val("poprst.wb1", 32'(observed()), 32'(e_wr(3'd0, 2'd1, 5'd8, 1'b0)));
        #2 reset = 1'b0;
        #1 check_val("poprst.async", 32'(observed()), 32'd0);
        @(negedge clk);
        check_val("poprst.held", 32'(observed()), 32'd0);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_val($sformatf("poprst.after%0d", j), 32'(observed()), 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            logic [2:0] op;
            logic [4:0] rt;
            int         r;
            int         k;
            op = 3'($urandom_range(0, 7));
            rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r  = $urandom_range(0, 19);
            k  = (r == 16) ? 15 : ((r > 16) ? -1 : r);
            run_txn($sformatf("rnd%0d", t), op, rt, 5'($urandom), 5'($urandom), k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
